// File: rtl/regbank_pkg.sv
// Shared constants and helpers for the register bank and its hex display scanner.
package regbank_pkg;

    localparam logic [0:6] SSEG_OFF   = 7'b1111111;
    localparam logic [5:0] AN_OFF     = 6'b111111;
    localparam int unsigned MAX_DIGITS = 6;

    // One display digit per 4 bits of register width.
    function automatic int unsigned nd_of(input int unsigned dataW);
        return dataW / 4;
    endfunction

    // Active-low segment pattern, bit 0 = segment a, bit 6 = segment g.
    function automatic logic [0:6] hex_to_sseg(input logic [3:0] nib);
        logic [0:6] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/regbank_sseg_scan.sv
// Multiplexed seven-segment scanner: walks 2*ND digits of a {Ra,Rb} bus, one per tick.
module sseg_scan
    import regbank_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned ND       = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [8*ND-1:0] datIn,
    output logic [5:0]      an,
    output logic [0:6]      sseg
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned NDIG  = 2 * ND;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {OFF, SCAN} scanState_t;

    scanState_t       state, nextState;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx, nextIdx, showIdx;
    logic [5:0]       nextAn;
    logic [0:6]       nextSseg;
    logic [3:0]       nibble;
    logic             tick;

    assign tick = (cnt == CNT_W'(SCAN_DIV - 1));

    // Free-running prescaler producing one tick every SCAN_DIV clocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end

    // State, digit index and display outputs; an and sseg load together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= OFF;
            idx   <= '0;
            an    <= AN_OFF;
            sseg  <= SSEG_OFF;
        end else begin
            state <= nextState;
            idx   <= nextIdx;
            an    <= nextAn;
            sseg  <= nextSseg;
        end
    end

    // Next digit selection, nibble mux and segment/anode decode.
    always_comb begin
        nextState = state;
        nextIdx   = idx;
        nextAn    = an;
        nextSseg  = sseg;
        showIdx   = idx;
        nibble    = '0;
        case (state)
            OFF: begin
                if (tick) begin
                    nextState = SCAN;
                    showIdx   = '0;
                end
            end
            SCAN: begin
                if (tick) showIdx = (idx == IDX_W'(NDIG - 1)) ? '0 : idx + IDX_W'(1);
            end
            default: nextState = OFF;
        endcase
        for (int d = 0; d < NDIG; d++) begin
            if (IDX_W'(d) == showIdx) nibble = datIn[4*d +: 4];
        end
        if (tick) begin
            nextIdx  = showIdx;
            nextAn   = AN_OFF & ~(6'(1) << showIdx);
            nextSseg = hex_to_sseg(nibble);
        end
    end

endmodule

// File: rtl/regbank_sseg.sv
// Parametrised register file with two registered read ports, write-first forwarding and hex display.
module regbank_sseg
    import regbank_pkg::*;
#(
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned ZERO_R0  = 0,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addrRa,
    input  logic [ADDR_W-1:0] addrRb,
    input  logic [ADDR_W-1:0] addrW,
    input  logic [DATA_W-1:0] datW,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] datOutRa,
    output logic [DATA_W-1:0] datOutRb,
    output logic [0:6]        sseg,
    output logic [5:0]        an
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned ND    = nd_of(DATA_W);

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wrEn;

    // Writes to a hard-wired zero register are dropped and never forwarded.
    assign wrEn = RegWrite && !((ZERO_R0 != 0) && (addrW == '0));

    // Register array; reset default i mod 2^DATA_W leaves register 0 at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= DATA_W'(i);
        end else if (wrEn) begin
            regs[addrW] <= datW;
        end
    end

    // Registered read ports with write-first bypass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            datOutRa <= '0;
            datOutRb <= '0;
        end else begin
            datOutRa <= (wrEn && (addrW == addrRa)) ? datW : regs[addrRa];
            datOutRb <= (wrEn && (addrW == addrRb)) ? datW : regs[addrRb];
        end
    end

    sseg_scan #(
        .SCAN_DIV(SCAN_DIV),
        .ND      (ND)
    ) u_scan (
        .clk  (clk),
        .rst  (rst),
        .datIn({datOutRa, datOutRb}),
        .an   (an),
        .sseg (sseg)
    );

endmodule

// File: tb/tb_regbank_sseg.sv
// Directed bench for regbank_sseg: 4-bit bank, 4-bit bank with zero register, 12-bit bank.
module tb_regbank_sseg;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  addrRa, addrRb, addrW;
    logic [11:0] datW;
    logic        RegWrite;

    logic [3:0]  ra4, rb4, raZ, rbZ;
    logic [11:0] ra12, rb12;
    logic [0:6]  sseg4, ssegZ, sseg12;
    logic [5:0]  an4, anZ, an12;

    int nChecks = 0;
    int nFails  = 0;

    logic [6:0] exp12 [6] = '{7'b0000110, 7'b0000001, 7'b0000001,
                              7'b0001000, 7'b1100000, 7'b0110001};

    always #5 clk = ~clk;

    regbank_sseg #(.DATA_W(4), .ADDR_W(3), .ZERO_R0(0), .SCAN_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .addrRa(addrRa), .addrRb(addrRb), .addrW(addrW),
        .datW(datW[3:0]), .RegWrite(RegWrite), .datOutRa(ra4), .datOutRb(rb4),
        .sseg(sseg4), .an(an4));

    regbank_sseg #(.DATA_W(4), .ADDR_W(3), .ZERO_R0(1), .SCAN_DIV(4)) dutZ (
        .clk(clk), .rst(rst), .addrRa(addrRa), .addrRb(addrRb), .addrW(addrW),
        .datW(datW[3:0]), .RegWrite(RegWrite), .datOutRa(raZ), .datOutRb(rbZ),
        .sseg(ssegZ), .an(anZ));

    regbank_sseg #(.DATA_W(12), .ADDR_W(3), .ZERO_R0(0), .SCAN_DIV(4)) dut12 (
        .clk(clk), .rst(rst), .addrRa(addrRa), .addrRb(addrRb), .addrW(addrW),
        .datW(datW), .RegWrite(RegWrite), .datOutRa(ra12), .datOutRb(rb12),
        .sseg(sseg12), .an(an12));

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        nChecks++;
        assert (obs === expv) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic edgeStep();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; addrRa = '0; addrRb = '0; addrW = '0; datW = '0; RegWrite = 1'b0;
        repeat (3) edgeStep();
        check("rst_ra4", 12'(ra4), 12'h0);
        check("rst_rb4", 12'(rb4), 12'h0);
        check("rst_an4", 12'(an4), 12'h3F);
        check("rst_sseg4", 12'(sseg4), 12'h7F);
        check("rst_an12", 12'(an12), 12'h3F);
        check("rst_anZ", 12'(anZ), 12'h3F);

        // Release and sweep defaults; first digit lights at edge 4.
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            addrRa = 3'(i);
            edgeStep();
            check("def_ra4", 12'(ra4), 12'(i));
            check("def_ra12", ra12, 12'(i));
            check("def_raZ", 12'(raZ), 12'(i));
            if (i < 3) check("pre_an4", 12'(an4), 12'h3F);
            if (i == 3) begin
                check("e4_an4", 12'(an4), 12'h3E);
                check("e4_sseg4", 12'(sseg4), 12'b0000001);
            end
            if (i == 7) begin
                check("e8_an4", 12'(an4), 12'h3D);
                check("e8_sseg4", 12'(sseg4), 12'b0100000);
            end
        end

        // Fill reg i with 15-i, then read back on both ports.
        RegWrite = 1'b1;
        for (int i = 0; i < 8; i++) begin
            addrW = 3'(i);
            datW  = 12'(15 - i);
            edgeStep();
        end
        RegWrite = 1'b0;
        for (int i = 0; i < 8; i++) begin
            addrRa = 3'(i);
            addrRb = 3'(7 - i);
            edgeStep();
            check("fill_ra4", 12'(ra4), 12'(15 - i));
            check("fill_rb4", 12'(rb4), 12'(8 + i));
            check("fill_ra12", ra12, 12'(15 - i));
            check("fill_raZ", 12'(raZ), (i == 0) ? 12'h0 : 12'(15 - i));
        end

        // Same-edge write and read of address 5 on both ports.
        addrW = 3'd5; addrRa = 3'd5; addrRb = 3'd5; datW = 12'h9; RegWrite = 1'b1;
        edgeStep();
        check("fwd_ra4", 12'(ra4), 12'h9);
        check("fwd_rb4", 12'(rb4), 12'h9);
        check("fwd_raZ", 12'(raZ), 12'h9);
        RegWrite = 1'b0; datW = '0;
        edgeStep();
        check("fwd_hold_ra4", 12'(ra4), 12'h9);
        check("fwd_hold_rb4", 12'(rb4), 12'h9);

        // Write to register 0: dropped on the zero-register bank, forwarded elsewhere.
        addrW = 3'd0; addrRa = 3'd0; datW = 12'h9; RegWrite = 1'b1;
        edgeStep();
        check("r0_same_raZ", 12'(raZ), 12'h0);
        check("r0_same_ra4", 12'(ra4), 12'h9);
        RegWrite = 1'b0;
        edgeStep();
        check("r0_after_raZ", 12'(raZ), 12'h0);
        check("r0_after_ra4", 12'(ra4), 12'h9);

        // Display scan: Ra = reg2 written with CBA at edge 1, Rb = default reg3.
        rst = 1'b0;
        addrRa = 3'd2; addrRb = 3'd3; addrW = 3'd2; datW = 12'hCBA; RegWrite = 1'b1;
        edgeStep();
        check("rst_hold_ra4", 12'(ra4), 12'h0);
        rst = 1'b1;
        for (int e = 1; e <= 28; e++) begin
            edgeStep();
            if (e == 1) begin
                RegWrite = 1'b0;
                check("scan_ra4", 12'(ra4), 12'hA);
                check("scan_ra12", ra12, 12'hCBA);
                check("scan_rb12", rb12, 12'h003);
            end
            if (e == 2) check("scan_pre_an12", 12'(an12), 12'h3F);
            if (e % 4 == 0) begin
                check("scan_an12", 12'(an12), 12'(6'h3F & ~(6'(1) << ((e / 4 - 1) % 6))));
                check("scan_sseg12", 12'(sseg12), 12'(exp12[(e / 4 - 1) % 6]));
                check("scan_an4", 12'(an4), ((e / 4) % 2 == 1) ? 12'h3E : 12'h3D);
                check("scan_sseg4", 12'(sseg4), ((e / 4) % 2 == 1) ? 12'b0000110 : 12'b0001000);
            end
        end

        // Reset between edges during a write while scanning.
        RegWrite = 1'b1; addrW = 3'd1; datW = 12'h00E;
        #2;
        rst = 1'b0;
        #1;
        check("mid_ra4", 12'(ra4), 12'h0);
        check("mid_rb4", 12'(rb4), 12'h0);
        check("mid_an4", 12'(an4), 12'h3F);
        check("mid_sseg4", 12'(sseg4), 12'h7F);
        check("mid_an12", 12'(an12), 12'h3F);
        check("mid_ra12", ra12, 12'h0);
        edgeStep();
        edgeStep();
        RegWrite = 1'b0;
        rst = 1'b1;
        addrRa = 3'd1; addrRb = 3'd2;
        edgeStep();
        check("post_ra4", 12'(ra4), 12'h1);
        check("post_rb4", 12'(rb4), 12'h2);
        check("post_ra12", ra12, 12'h1);
        check("post_rb12", rb12, 12'h2);
        check("post_an4", 12'(an4), 12'h3F);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
